// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with optional two-entry skid buffer and a
// saturating back-pressure counter.
module ex_mem_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              e_valid,
    output logic              e_ready,
    input  logic [3:0]        e_ctrl,
    input  logic [DATA_W-1:0] e_alu_out,
    input  logic [DATA_W-1:0] e_wdata,
    input  logic [REG_W-1:0]  e_wreg,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [3:0]        m_ctrl,
    output logic [DATA_W-1:0] m_alu_out,
    output logic [DATA_W-1:0] m_wdata,
    output logic [REG_W-1:0]  m_wreg,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit          HasSkid = (SKID != 0);
    localparam int unsigned EntW    = 4 + 2 * DATA_W + REG_W;

    typedef logic [EntW-1:0] entry_t;

    entry_t           in_ent;
    entry_t           m_ent_q, m_ent_d;
    entry_t           s_ent_q, s_ent_d;
    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       m_ctrl_raw;
    logic             in_fire, out_fire;

    assign in_ent   = {e_ctrl, e_alu_out, e_wdata, e_wreg};
    assign in_fire  = e_valid & e_ready;
    assign out_fire = m_valid_q & m_ready;

    // Next-state for main/skid entries: flush beats refill from S beats input load.
    always_comb begin
        m_ent_d   = m_ent_q;
        s_ent_d   = s_ent_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (out_fire && s_valid_q) begin
            m_ent_d   = s_ent_q;
            m_valid_d = 1'b1;
            s_valid_d = 1'b0;
        end else if (in_fire && (!m_valid_q || out_fire)) begin
            m_ent_d   = in_ent;
            m_valid_d = 1'b1;
        end else if (in_fire && HasSkid) begin
            // M is occupied and not draining: park the new entry in S.
            s_ent_d   = in_ent;
            s_valid_d = 1'b1;
        end else if (out_fire) begin
            m_valid_d = 1'b0;
        end
    end

    // Stall counter saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (m_valid_q && !m_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset clears valids, data and counter asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ent_q   <= '0;
            s_ent_q   <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            m_ent_q   <= m_ent_d;
            s_ent_q   <= s_ent_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    generate
        if (HasSkid) begin : g_skid_ready
            logic e_ready_q;
            // Registered ready mirrors !S.valid, so m_ready never reaches e_ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    e_ready_q <= 1'b0;
                end else begin
                    e_ready_q <= !s_valid_d;
                end
            end
            assign e_ready = e_ready_q;
        end else begin : g_pass_ready
            assign e_ready = m_ready | !m_valid_q;
        end
    endgenerate

    assign {m_ctrl_raw, m_alu_out, m_wdata, m_wreg} = m_ent_q;
    // An empty slot must never assert any control bit downstream.
    assign m_ctrl    = m_ctrl_raw & {4{m_valid_q}};
    assign m_valid   = m_valid_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: skid mode, pass-through mode and a
// narrow saturating counter, each on its own instance.
module tb_ex_mem_pipe_reg;

    logic clk;
    logic rst_n;

    // Instance a: SKID=1, CNT_W=16
    logic        a_flush, a_e_valid, a_e_ready, a_m_valid, a_m_ready;
    logic [3:0]  a_e_ctrl, a_m_ctrl;
    logic [31:0] a_e_alu, a_e_wdata, a_m_alu, a_m_wdata;
    logic [4:0]  a_e_wreg, a_m_wreg;
    logic [15:0] a_cnt;

    // Instance b: SKID=0, CNT_W=16
    logic        b_flush, b_e_valid, b_e_ready, b_m_valid, b_m_ready;
    logic [3:0]  b_e_ctrl, b_m_ctrl;
    logic [31:0] b_e_alu, b_e_wdata, b_m_alu, b_m_wdata;
    logic [4:0]  b_e_wreg, b_m_wreg;
    logic [15:0] b_cnt;

    // Instance c: SKID=1, CNT_W=4
    logic        c_flush, c_e_valid, c_e_ready, c_m_valid, c_m_ready;
    logic [3:0]  c_e_ctrl, c_m_ctrl;
    logic [31:0] c_e_alu, c_e_wdata, c_m_alu, c_m_wdata;
    logic [4:0]  c_e_wreg, c_m_wreg;
    logic [3:0]  c_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .SKID(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .e_valid(a_e_valid), .e_ready(a_e_ready), .e_ctrl(a_e_ctrl),
        .e_alu_out(a_e_alu), .e_wdata(a_e_wdata), .e_wreg(a_e_wreg),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_ctrl(a_m_ctrl),
        .m_alu_out(a_m_alu), .m_wdata(a_m_wdata), .m_wreg(a_m_wreg),
        .stall_cnt(a_cnt)
    );

    ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .SKID(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .e_valid(b_e_valid), .e_ready(b_e_ready), .e_ctrl(b_e_ctrl),
        .e_alu_out(b_e_alu), .e_wdata(b_e_wdata), .e_wreg(b_e_wreg),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_ctrl(b_m_ctrl),
        .m_alu_out(b_m_alu), .m_wdata(b_m_wdata), .m_wreg(b_m_wreg),
        .stall_cnt(b_cnt)
    );

    ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .SKID(1), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush),
        .e_valid(c_e_valid), .e_ready(c_e_ready), .e_ctrl(c_e_ctrl),
        .e_alu_out(c_e_alu), .e_wdata(c_e_wdata), .e_wreg(c_e_wreg),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_ctrl(c_m_ctrl),
        .m_alu_out(c_m_alu), .m_wdata(c_m_wdata), .m_wreg(c_m_wreg),
        .stall_cnt(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [31:0] alu, input logic [3:0] ctrl);
        a_e_valid = 1'b1;
        a_e_alu   = alu;
        a_e_ctrl  = ctrl;
        a_e_wdata = ~alu;
        a_e_wreg  = alu[4:0];
    endtask

    initial begin
        rst_n = 1'b0;
        {a_flush, a_e_valid, a_m_ready, a_e_ctrl, a_e_alu, a_e_wdata, a_e_wreg} = '0;
        {b_flush, b_e_valid, b_m_ready, b_e_ctrl, b_e_alu, b_e_wdata, b_e_wreg} = '0;
        {c_flush, c_e_valid, c_m_ready, c_e_ctrl, c_e_alu, c_e_wdata, c_e_wreg} = '0;

        // Reset state
        #2;
        check_eq("rst_m_valid", 32'(a_m_valid), 32'd0);
        check_eq("rst_m_ctrl", 32'(a_m_ctrl), 32'd0);
        check_eq("rst_m_alu", a_m_alu, 32'd0);
        check_eq("rst_stall_cnt", 32'(a_cnt), 32'd0);
        check_eq("rst_e_ready_low", 32'(a_e_ready), 32'd0);
        #10;
        rst_n = 1'b1;
        step();
        check_eq("rst_e_ready_after", 32'(a_e_ready), 32'd1);

        // Streaming with m_ready held high
        a_m_ready = 1'b1;
        a_send(32'h10, 4'b1000);
        step();
        check_eq("stream_0x10", a_m_alu, 32'h10);
        check_eq("stream_ready0", 32'(a_e_ready), 32'd1);
        a_send(32'h14, 4'b1000);
        step();
        check_eq("stream_0x14", a_m_alu, 32'h14);
        a_send(32'h18, 4'b1000);
        step();
        check_eq("stream_0x18", a_m_alu, 32'h18);
        check_eq("stream_wdata", a_m_wdata, ~32'h18);
        check_eq("stream_ready2", 32'(a_e_ready), 32'd1);
        a_e_valid = 1'b0;
        step();
        check_eq("stream_drained", 32'(a_m_valid), 32'd0);
        check_eq("stream_stall_cnt", 32'(a_cnt), 32'd0);

        // memread-only entry, then control gating on an empty slot
        a_e_valid = 1'b1;
        a_e_ctrl  = 4'b0001;
        a_e_wreg  = 5'd9;
        step();
        check_eq("memread_ctrl", 32'(a_m_ctrl), 32'h1);
        check_eq("memread_wreg", 32'(a_m_wreg), 32'd9);
        a_e_valid = 1'b0;
        a_e_wreg  = 5'd3;
        step();
        check_eq("empty_ctrl_gated", 32'(a_m_ctrl), 32'h0);
        check_eq("empty_wreg_held", 32'(a_m_wreg), 32'd9);

        // Back-pressure: A in M, B into S, three stalled edges total
        a_m_ready = 1'b0;
        a_send(32'hA, 4'b1000);
        step();
        a_send(32'hB, 4'b0100);
        step();
        check_eq("bp_ready_low", 32'(a_e_ready), 32'd0);
        a_e_valid = 1'b0;
        a_e_alu   = 32'hDEAD;
        step();
        step();
        check_eq("bp_stall_cnt", 32'(a_cnt), 32'd3);
        check_eq("bp_head_A", a_m_alu, 32'hA);
        check_eq("bp_head_ctrl", 32'(a_m_ctrl), 32'h8);
        a_m_ready = 1'b1;
        step();
        check_eq("bp_next_B", a_m_alu, 32'hB);
        check_eq("bp_next_ctrl", 32'(a_m_ctrl), 32'h4);
        check_eq("bp_ready_back", 32'(a_e_ready), 32'd1);
        step();
        check_eq("bp_empty", 32'(a_m_valid), 32'd0);
        check_eq("bp_cnt_final", 32'(a_cnt), 32'd3);

        // Flush with M and S full plus a concurrent offer
        a_m_ready = 1'b0;
        a_send(32'hC, 4'b1010);
        step();
        a_send(32'hD, 4'b1010);
        step();
        a_send(32'hE, 4'b1010);
        a_flush = 1'b1;
        step();
        check_eq("flush_m_valid", 32'(a_m_valid), 32'd0);
        check_eq("flush_m_ctrl", 32'(a_m_ctrl), 32'h0);
        check_eq("flush_e_ready", 32'(a_e_ready), 32'd1);
        check_eq("flush_data_held", a_m_alu, 32'hC);
        a_flush   = 1'b0;
        a_e_valid = 1'b0;
        step();
        check_eq("flush_no_E", 32'(a_m_valid), 32'd0);

        // Asynchronous reset between edges with two entries held
        a_send(32'hF0, 4'b1111);
        step();
        a_send(32'hF4, 4'b1111);
        step();
        a_e_valid = 1'b0;
        check_eq("arst_pre_valid", 32'(a_m_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_m_valid", 32'(a_m_valid), 32'd0);
        check_eq("arst_m_ctrl", 32'(a_m_ctrl), 32'h0);
        check_eq("arst_m_alu", a_m_alu, 32'd0);
        check_eq("arst_m_wdata", a_m_wdata, 32'd0);
        check_eq("arst_stall_cnt", 32'(a_cnt), 32'd0);
        check_eq("arst_e_ready", 32'(a_e_ready), 32'd0);
        #1;
        rst_n = 1'b1;
        a_m_ready = 1'b1;
        step();
        check_eq("arst_after_valid", 32'(a_m_valid), 32'd0);
        step();
        check_eq("arst_still_empty", 32'(a_m_valid), 32'd0);

        // SKID=0: e_ready follows m_ready combinationally
        b_m_ready = 1'b0;
        b_e_valid = 1'b1;
        b_e_alu   = 32'hA;
        #1;
        check_eq("p0_ready_empty", 32'(b_e_ready), 32'd1);
        step();
        check_eq("p0_head_A", b_m_alu, 32'hA);
        check_eq("p0_ready_blocked", 32'(b_e_ready), 32'd0);
        b_m_ready = 1'b1;
        b_e_alu   = 32'hB;
        #1;
        check_eq("p0_ready_track", 32'(b_e_ready), 32'd1);
        step();
        check_eq("p0_head_B", b_m_alu, 32'hB);
        b_e_valid = 1'b0;
        b_m_ready = 1'b0;
        #1;
        check_eq("p0_ready_drop", 32'(b_e_ready), 32'd0);
        step();
        check_eq("p0_stall_cnt", 32'(b_cnt), 32'd1);
        check_eq("p0_hold_B", b_m_alu, 32'hB);

        // CNT_W=4 saturation over 20 stalled edges
        c_m_ready = 1'b0;
        c_e_valid = 1'b1;
        c_e_alu   = 32'h55;
        step();
        c_e_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_eq("sat_cnt_F", 32'(c_cnt), 32'hF);
        step();
        step();
        check_eq("sat_cnt_hold", 32'(c_cnt), 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
